xga_video_timing: RTL and testbench

- Raster timing generator sitting directly upstream of the scrolling background renderers.
- Produces pix_x, pix_y, video_active, hsync and vsync in the exact form the background layers consume.
- Default timing is 1024x768 @ 60 Hz (XGA, 65 MHz pixel rate).
- Also provides frame/line strobes and a frame counter, so downstream animation logic can step on a clean single-cycle pulse instead of a vsync edge.

---
 rtl/xga_video_timing_if.sv | 38 +++
 rtl/xga_video_timing.sv | 128 ++++++++++++
 tb/tb_xga_video_timing.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xga_video_timing_if.sv
// ---------------------------------------------------------------------------
// xga_video_timing_if
//   Bundle between the raster timing generator and the background renderers.
//   master : timing generator (drives position, flags, strobes, frame count;
//            receives the pixel advance enable)
//   slave  : downstream consumer (drives pix_ce, observes everything else)
//   Signals:
//     pix_ce        pixel advance enable
//     pix_x/pix_y   current raster position (11 bits each)
//     video_active  position lies inside the visible area
//     hsync/vsync   sync outputs, SYNC_POL level inside their windows
//     line_start    single-cycle pulse when pix_x has wrapped to 0
//     frame_start   single-cycle pulse when pix_x and pix_y have wrapped to 0
//     frame_count   frames completed since reset (10 bits, wraps)
// ---------------------------------------------------------------------------
interface xga_video_timing_if;
  logic        pix_ce;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        video_active;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [9:0]  frame_count;

  modport master (
    input  pix_ce,
    output pix_x, pix_y, video_active, hsync, vsync,
           line_start, frame_start, frame_count
  );

  modport slave (
    output pix_ce,
    input  pix_x, pix_y, video_active, hsync, vsync,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/xga_video_timing.sv
// ---------------------------------------------------------------------------
// xga_video_timing
//   Raster timing generator for the scrolling background renderers.
//   Default timing is 1024x768 @ 60 Hz (65 MHz pixel clock).
//   Ports:
//     clk   pixel clock (single domain)
//     rst   synchronous, active-high reset
//     vid   xga_video_timing_if.master: pix_ce in; pix_x, pix_y,
//           video_active, hsync, vsync, line_start, frame_start,
//           frame_count out
//   Every output is a register loaded from a decode of the *next* counter
//   values, so all flags describe exactly the position shown on pix_x/pix_y
//   in the same cycle.
// ---------------------------------------------------------------------------
module xga_video_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  xga_video_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The position counters are 11 bits wide; larger rasters cannot be counted.
  if (H_TOTAL > 2048) begin : g_h_total_check
    $error("xga_video_timing: H_TOTAL (%0d) exceeds 2048", H_TOTAL);
  end
  if (V_TOTAL > 2048) begin : g_v_total_check
    $error("xga_video_timing: V_TOTAL (%0d) exceeds 2048", V_TOTAL);
  end

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Window bounds kept at 12 bits: an end bound may legitimately equal 2048.
  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  logic [10:0] pix_x_reg, pix_x_next;
  logic [10:0] pix_y_reg, pix_y_next;
  logic [9:0]  frame_count_reg, frame_count_next;
  logic        video_active_reg, video_active_next;
  logic        hsync_reg, hsync_next;
  logic        vsync_reg, vsync_next;
  logic        line_start_reg, frame_start_reg;
  logic        x_wrap, y_wrap;
  logic [11:0] x_ext, y_ext;

  always_comb begin
    x_wrap            = (pix_x_reg == H_LAST);
    y_wrap            = (pix_y_reg == V_LAST);
    pix_x_next        = pix_x_reg + 11'd1;
    pix_y_next        = pix_y_reg;
    frame_count_next  = frame_count_reg;

    if (x_wrap) begin
      pix_x_next = 11'd0;
      if (y_wrap) begin
        pix_y_next       = 11'd0;
        frame_count_next = frame_count_reg + 10'd1;
      end else begin
        pix_y_next = pix_y_reg + 11'd1;
      end
    end

    // Flags decoded from the position the counters are about to take, so
    // the registered flags line up with the registered position.
    x_ext             = {1'b0, pix_x_next};
    y_ext             = {1'b0, pix_y_next};
    video_active_next = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    hsync_next        = ((x_ext >= HS_START) && (x_ext < HS_END)) ? SYNC_ON : SYNC_OFF;
    vsync_next        = ((y_ext >= VS_START) && (y_ext < VS_END)) ? SYNC_ON : SYNC_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x_reg        <= 11'd0;
      pix_y_reg        <= 11'd0;
      frame_count_reg  <= 10'd0;
      video_active_reg <= 1'b1;
      hsync_reg        <= SYNC_OFF;
      vsync_reg        <= SYNC_OFF;
      line_start_reg   <= 1'b0;
      frame_start_reg  <= 1'b0;
    end else if (vid.pix_ce) begin
      pix_x_reg        <= pix_x_next;
      pix_y_reg        <= pix_y_next;
      frame_count_reg  <= frame_count_next;
      video_active_reg <= video_active_next;
      hsync_reg        <= hsync_next;
      vsync_reg        <= vsync_next;
      // Strobes mark the cycle in which the wrap has just happened.
      line_start_reg   <= x_wrap;
      frame_start_reg  <= x_wrap && y_wrap;
    end else begin
      // Position and levels hold; strobes never stretch across a stall.
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign vid.pix_x        = pix_x_reg;
  assign vid.pix_y        = pix_y_reg;
  assign vid.frame_count  = frame_count_reg;
  assign vid.video_active = video_active_reg;
  assign vid.hsync        = hsync_reg;
  assign vid.vsync        = vsync_reg;
  assign vid.line_start   = line_start_reg;
  assign vid.frame_start  = frame_start_reg;

endmodule

// File: tb/tb_xga_video_timing.sv
// ---------------------------------------------------------------------------
// tb_xga_video_timing
//   Two small-raster instances: A (8x4 active, active-low syncs) for raster,
//   enable and reset behaviour; B (2x2 active, active-high syncs) for the
//   frame counter wrap over 1025 frames. Expected outputs come from an
//   arithmetic model: position = enabled-cycle count divided down by the
//   raster totals.
// ---------------------------------------------------------------------------
module tb_xga_video_timing;

  localparam int A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int A_VA = 4, A_VFP = 1, A_VS = 2, A_VBP = 1;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
  localparam int A_FR = A_HT * A_VT;

  localparam int B_HA = 2, B_HFP = 1, B_HS = 1, B_HBP = 1;
  localparam int B_VA = 2, B_VFP = 1, B_VS = 1, B_VBP = 1;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
  localparam int B_FR = B_HT * B_VT;

  // {pix_x, pix_y, video_active, hsync, vsync, line_start, frame_start, frame_count}
  localparam logic [36:0] A_RST = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
  localparam logic [36:0] B_RST = {11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  xga_video_timing_if ifa();
  xga_video_timing_if ifb();

  xga_video_timing #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .SYNC_POL(1'b0)
  ) u_dut_a (.clk(clk), .rst(rst_a), .vid(ifa));

  xga_video_timing #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SYNC_POL(1'b1)
  ) u_dut_b (.clk(clk), .rst(rst_b), .vid(ifb));

  logic [36:0] obs_a, obs_b;
  assign obs_a = {ifa.pix_x, ifa.pix_y, ifa.video_active, ifa.hsync, ifa.vsync,
                  ifa.line_start, ifa.frame_start, ifa.frame_count};
  assign obs_b = {ifb.pix_x, ifb.pix_y, ifb.video_active, ifb.hsync, ifb.vsync,
                  ifb.line_start, ifb.frame_start, ifb.frame_count};

  int n_vec = 0;
  int n_err = 0;

  // Model state: enabled cycles since reset, and whether the last edge advanced.
  longint na = 0, nb = 0;
  bit adv_a = 1'b0, adv_b = 1'b0;

  function automatic logic [36:0] model(longint n, bit adv, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp, bit pol);
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    longint x = n % ht;
    longint y = (n / ht) % vt;
    longint fc = (n / (ht * vt)) % 1024;
    bit act = (x < ha) && (y < va);
    bit hin = (x >= ha + hfp) && (x < ha + hfp + hsw);
    bit vin = (y >= va + vfp) && (y < va + vfp + vsw);
    bit ls = adv && (x == 0);
    bit fs = ls && (y == 0);
    return {11'(x), 11'(y), act, hin ? pol : ~pol, vin ? pol : ~pol, ls, fs, 10'(fc)};
  endfunction

  function automatic logic [36:0] exp_a();
    return model(na, adv_a, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, 1'b0);
  endfunction

  function automatic logic [36:0] exp_b();
    return model(nb, adv_b, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1);
  endfunction

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic clk_step(input bit ra, input bit ca, input bit rb, input bit cb);
    @(negedge clk);
    rst_a = ra; ifa.pix_ce = ca;
    rst_b = rb; ifb.pix_ce = cb;
    @(posedge clk);
    #1;
    if (ra) begin na = 0; adv_a = 1'b0; end
    else if (ca) begin na++; adv_a = 1'b1; end
    else adv_a = 1'b0;
    if (rb) begin nb = 0; adv_b = 1'b0; end
    else if (cb) begin nb++; adv_b = 1'b1; end
    else adv_b = 1'b0;
  endtask

  task automatic test_reset();
    clk_step(1'b1, 1'($urandom), 1'b1, 1'($urandom));
    clk_step(1'b1, 1'($urandom), 1'b1, 1'($urandom));
    n_vec++;
    if (obs_a !== A_RST) begin
      n_err++; $display("FAIL reset_a got=%h exp=%h", obs_a, A_RST);
    end
    n_vec++;
    if (obs_b !== B_RST) begin
      n_err++; $display("FAIL reset_b got=%h exp=%h", obs_b, B_RST);
    end
  endtask

  task automatic test_full_frame();
    int fs_cnt = 0, fs_cyc = -1, fs_fc = -1;
    for (int cyc = 1; cyc <= A_FR; cyc++) begin
      clk_step(1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (obs_a !== exp_a()) begin
        n_err++; $display("FAIL full_frame cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a());
      end
      if (ifa.frame_start) begin
        fs_cnt++; fs_cyc = cyc; fs_fc = int'(ifa.frame_count);
      end
    end
    n_vec++;
    if (fs_cnt !== 1 || fs_cyc !== A_FR || fs_fc !== 1) begin
      n_err++;
      $display("FAIL frame_start_once got cnt=%0d cyc=%0d fc=%0d exp cnt=1 cyc=%0d fc=1",
               fs_cnt, fs_cyc, fs_fc, A_FR);
    end
    $display("full_frame: %0d cycles, frame_start at %0d", A_FR, fs_cyc);
  endtask

  task automatic test_line_timing();
    int hs_cnt = 0, hs_first = -1, va_cnt = 0, exp_va, guard = 0;
    while ((na % A_HT) != 0 && guard < A_HT) begin
      clk_step(1'b0, 1'b1, 1'b1, 1'b0); guard++;
    end
    exp_va = (((na / A_HT) % A_VT) < A_VA) ? A_HA : 0;
    for (int i = 0; i < A_HT; i++) begin
      if (i > 0) clk_step(1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (obs_a !== exp_a()) begin
        n_err++; $display("FAIL line_timing i=%0d got=%h exp=%h", i, obs_a, exp_a());
      end
      if (ifa.hsync == 1'b0) begin
        if (hs_first < 0) hs_first = int'(ifa.pix_x);
        hs_cnt++;
      end
      if (ifa.video_active) va_cnt++;
    end
    n_vec++;
    if (hs_cnt !== A_HS || hs_first !== A_HA + A_HFP) begin
      n_err++;
      $display("FAIL hsync_window got cnt=%0d first=%0d exp cnt=%0d first=%0d",
               hs_cnt, hs_first, A_HS, A_HA + A_HFP);
    end
    n_vec++;
    if (va_cnt !== exp_va) begin
      n_err++; $display("FAIL line_active got=%0d exp=%0d", va_cnt, exp_va);
    end
    $display("line_timing: hsync %0d cycles from x=%0d, active %0d", hs_cnt, hs_first, va_cnt);
  endtask

  task automatic test_frame_timing();
    int vs_cnt = 0, vs_first = -1, vs_last = -1, va_cnt = 0, ls_cnt = 0, exp_ls, guard = 0;
    while ((na % A_FR) != 0 && guard < A_FR) begin
      clk_step(1'b0, 1'b1, 1'b1, 1'b0); guard++;
    end
    exp_ls = A_VT - 1 + int'(adv_a);
    for (int i = 0; i < A_FR; i++) begin
      if (i > 0) clk_step(1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (obs_a !== exp_a()) begin
        n_err++; $display("FAIL frame_timing i=%0d got=%h exp=%h", i, obs_a, exp_a());
      end
      if (ifa.vsync == 1'b0) begin
        if (vs_first < 0) vs_first = i;
        vs_last = i; vs_cnt++;
      end
      if (ifa.video_active) va_cnt++;
      if (ifa.line_start) ls_cnt++;
    end
    n_vec++;
    if (vs_cnt !== A_VS * A_HT || vs_first !== (A_VA + A_VFP) * A_HT
        || vs_last - vs_first + 1 !== vs_cnt) begin
      n_err++;
      $display("FAIL vsync_window got cnt=%0d first=%0d last=%0d exp cnt=%0d first=%0d",
               vs_cnt, vs_first, vs_last, A_VS * A_HT, (A_VA + A_VFP) * A_HT);
    end
    n_vec++;
    if (va_cnt !== A_HA * A_VA) begin
      n_err++; $display("FAIL frame_active got=%0d exp=%0d", va_cnt, A_HA * A_VA);
    end
    n_vec++;
    if (ls_cnt !== exp_ls) begin
      n_err++; $display("FAIL line_starts got=%0d exp=%0d", ls_cnt, exp_ls);
    end
    $display("frame_timing: vsync %0d cycles, active %0d, line_start %0d", vs_cnt, va_cnt, ls_cnt);
  endtask

  task automatic test_ce_random();
    bit prev_ls = 1'b0;
    for (int i = 0; i < 300; i++) begin
      clk_step(1'b0, 1'($urandom), 1'b1, 1'b0);
      n_vec++;
      if (obs_a !== exp_a()) begin
        n_err++; $display("FAIL ce_random i=%0d got=%h exp=%h", i, obs_a, exp_a());
      end
      n_vec++;
      if (prev_ls && ifa.line_start) begin
        n_err++; $display("FAIL strobe_stretch i=%0d got=1 exp=0", i);
      end
      prev_ls = ifa.line_start;
    end
    $display("ce_random: 300 cycles, model position n=%0d", na);
  endtask

  task automatic test_ce_toggle();
    int first_fs = -1, guard = 0;
    while ((na % A_FR) != 0 && guard < A_FR) begin
      clk_step(1'b0, 1'b1, 1'b1, 1'b0); guard++;
    end
    for (int cyc = 1; cyc <= 2 * A_FR + 4; cyc++) begin
      clk_step(1'b0, 1'(cyc % 2 == 0), 1'b1, 1'b0);
      n_vec++;
      if (obs_a !== exp_a()) begin
        n_err++; $display("FAIL ce_toggle cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a());
      end
      if (ifa.frame_start && first_fs < 0) first_fs = cyc;
    end
    n_vec++;
    if (first_fs !== 2 * A_FR) begin
      n_err++; $display("FAIL half_rate_frame got=%0d exp=%0d", first_fs, 2 * A_FR);
    end
    $display("ce_toggle: frame took %0d cycles", first_fs);
  endtask

  task automatic test_mid_reset();
    int k = int'($urandom_range(A_FR + 1, 3 * A_FR));
    int first_fs = -1;
    for (int i = 0; i < k; i++) clk_step(1'b0, 1'b1, 1'b1, 1'b0);
    clk_step(1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (obs_a !== A_RST) begin
      n_err++; $display("FAIL mid_reset after %0d got=%h exp=%h", k, obs_a, A_RST);
    end
    for (int cyc = 1; cyc <= A_FR; cyc++) begin
      clk_step(1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (obs_a !== exp_a()) begin
        n_err++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a());
      end
      if (ifa.frame_start && first_fs < 0) first_fs = cyc;
    end
    n_vec++;
    if (first_fs !== A_FR) begin
      n_err++; $display("FAIL post_reset_frame got=%0d exp=%0d", first_fs, A_FR);
    end
    $display("mid_reset: reset after %0d cycles, next frame_start at %0d", k, first_fs);
  endtask

  task automatic test_frame_wrap();
    int wrap_cyc = -1;
    for (int cyc = 1; cyc <= 1025 * B_FR; cyc++) begin
      clk_step(1'b1, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (obs_b !== exp_b()) begin
        n_err++; $display("FAIL wrap_run cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b());
      end
      if (ifb.frame_start && ifb.frame_count == 10'd0 && wrap_cyc < 0) wrap_cyc = cyc;
    end
    n_vec++;
    if (wrap_cyc !== 1024 * B_FR) begin
      n_err++; $display("FAIL frame_count_wrap got=%0d exp=%0d", wrap_cyc, 1024 * B_FR);
    end
    $display("frame_wrap: frame_count returned to 0 at cycle %0d", wrap_cyc);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.pix_ce = 1'b0; ifb.pix_ce = 1'b0;
    test_reset();
    test_full_frame();
    test_line_timing();
    test_frame_timing();
    test_ce_random();
    test_ce_toggle();
    test_mid_reset();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
